trigger_capture: RTL
====================

Name: trigger_capture

Overview:
- Parametrised successor to the level trigger: hysteretic edge trigger with selectable slope, sample decimation, programmable pre-trigger depth and a single-port-read circular capture memory.
- Sits between the ADC sample stream and the display/readout logic. Replaces the flat 512-entry output array with an addressed read port of one-cycle latency.
- Emits a DEPTH-sample frame, addressed relative to its oldest sample, once a capture completes.

Parameters:
DATA_W, 12, sample width (bits)
DEPTH, 512, frame length in samples; must be a power of two, at least 4
ADDR_W, $clog2(DEPTH), address width
DECIM_W, 12, decimation-ratio width
HYST, 8, hysteresis half-band in LSBs

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
data_input  in  DATA_W  ADC sample, unsigned
ready  in  1  data_input valid this cycle
level  in  DATA_W  trigger level, unsigned
edge_sel  in  1  0 = rising, 1 = falling
decim  in  DECIM_W  keep 1 of every decim+1 valid samples
pretrig  in  ADDR_W  samples retained before the trigger sample
arm  in  1  single-cycle pulse that starts or restarts a capture
force_trig  in  1  trigger immediately when ARMED (auto mode)
rd_addr  in  ADDR_W  frame-relative read index; 0 = oldest sample
rd_data  out  DATA_W  frame[rd_addr], registered
busy  out  1  capture in progress (PRE, ARMED, POST)
done  out  1  frame valid; held until next arm

Behaviour:
- Reset (async): state=IDLE, busy=0, done=0, rd_data=0. All counters and pointers are 0 and primed=0. Memory contents are not reset.
- Decimation:
  - A divider counter dcnt increments on each ready=1 cycle.
  - An accepted sample occurs when ready=1 and dcnt==decim; dcnt then returns to 0.
  - decim=0 accepts every valid sample. dcnt clears on arm.
  - decim is sampled live.
- Latching on arm: pretrig is latched on arm. A latched value >DEPTH-1 is impossible by width. pretrig=0 is legal.
- Thresholds are computed in DATA_W+1 bits and saturate:
  - lo = max(level-HYST, 0)
  - hi = min(level+HYST, 2^DATA_W-1)
- Rising slope:
  - primed sets on an accepted sample < lo.
  - Trigger on an accepted sample >= hi while primed.
- Falling slope: primed sets on an accepted sample > hi. Trigger on an accepted sample <= lo while primed.
- primed clears on arm and on trigger. edge_sel is latched on arm.
- Every accepted sample in PRE, ARMED and POST is written to mem[wptr], and wptr increments mod DEPTH.
- States:
  - IDLE: busy=0. arm -> PRE and clears wptr, pcnt and primed.
  - PRE: counts pretrig accepted samples, then -> ARMED. If pretrig=0, PRE lasts zero samples and arm goes straight to ARMED. Trigger conditions are ignored in PRE, but primed may set.
  - ARMED:
    - A trigger is an accepted sample meeting the slope condition, or force_trig=1 on an accepted-sample cycle.
    - The trigger sample is written at address T and is counted as the first post sample. The block records start=(T-pretrig) mod DEPTH, loads post count = DEPTH-1-pretrig, then -> POST.
    - If the post count is 0 (pretrig=DEPTH-1), it goes straight to DONE instead of POST.
    - Writes wrap freely while waiting, so the pretrig samples immediately preceding T are always retained.
  - POST: decrements on each accepted sample; -> DONE after the last one is written.
  - DONE: busy=0, done=1. Writes stop.
- arm has priority in every state:
  - It aborts any capture and restarts at PRE the next cycle.
  - done drops the cycle after arm.
  - arm coincident with an accepted sample discards that sample.
- Read port:
  - rd_data <= mem[(start+rd_addr) mod DEPTH] every cycle, giving 1-cycle latency.
  - If a write and a read hit the same address in a cycle, the read returns the old data (read-first).
  - Contents are meaningful only while done=1.
- ready=0 freezes dcnt and all capture progress. The state machine does not time out.
- Mid-capture async rst returns to IDLE immediately. done stays 0 until a new arm completes.

Test Plan:
- Rising trigger:
  - Stimulus: DEPTH=16, level=100, HYST=8, pretrig=4, decim=0, ready=1. Ramp 0,10,...,250 repeating, then arm.
  - Required: first trigger on sample 110. After done, rd_addr 0..15 read 70,80,90,100,110,120,...,220.
- Falling slope and hysteresis:
  - Stimulus: edge_sel=1, samples 120,100,95,93,91.
  - Required: the 91 sample (<=92) triggers. Samples 95 and 93 do not.
  - Required: a signal oscillating between 95 and 105 never triggers (busy stays 1).
- Decimation:
  - Stimulus: decim=2, ready=1, counter input 0,1,2,...
  - Required: the captured frame holds 2,5,8,... (every third sample). With ready toggling 1/0, the frame content is identical.
- force_trig and pretrig boundaries:
  - pretrig=0, force_trig held high: frame = first DEPTH accepted samples after arm.
  - pretrig=DEPTH-1 with a trigger: rd_addr DEPTH-1 returns the trigger sample, and done rises the cycle after the trigger write.
- Re-arm and reset:
  - Stimulus: arm in POST.
  - Required: busy stays 1, done stays 0, and a fresh PRE begins with a correct new frame.
  - Stimulus: async rst mid-ARMED.
  - Required: busy=0, done=0 and rd_data=0 immediately, with no clock edge needed.
- Saturation:
  - level=4095, HYST=8: hi=4095, so a rising trigger needs sample 4095.
  - level=3, edge_sel=1: lo=0, so a falling trigger needs sample 0.

Source files
------------

// File: rtl/trigger_capture_if.sv
// ---------------------------------------------------------------------------
// trigger_capture_if
//   Bundles the sample stream, trigger controls and frame read port of
//   trigger_capture.
//
//   master : the side that supplies samples, trigger settings and read
//            addresses (readout logic / testbench)
//   slave  : trigger_capture itself
//
//   data_input  ADC sample, unsigned
//   ready       data_input valid this cycle
//   level       trigger level, unsigned
//   edge_sel    0 = rising, 1 = falling
//   decim       keep 1 of every decim+1 valid samples
//   pretrig     samples retained before the trigger sample
//   arm         single-cycle pulse that starts or restarts a capture
//   force_trig  trigger on the next accepted sample while ARMED
//   rd_addr     frame-relative read index, 0 = oldest sample
//   rd_data     frame[rd_addr], one cycle after rd_addr
//   busy        capture in progress
//   done        frame valid, held until the next arm
// ---------------------------------------------------------------------------
interface trigger_capture_if #(
  parameter int DATA_W  = 12,
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int DECIM_W = 12
);
  logic [DATA_W-1:0]  data_input;
  logic               ready;
  logic [DATA_W-1:0]  level;
  logic               edge_sel;
  logic [DECIM_W-1:0] decim;
  logic [ADDR_W-1:0]  pretrig;
  logic               arm;
  logic               force_trig;
  logic [ADDR_W-1:0]  rd_addr;
  logic [DATA_W-1:0]  rd_data;
  logic               busy;
  logic               done;

  modport master (
    output data_input, ready, level, edge_sel, decim, pretrig,
           arm, force_trig, rd_addr,
    input  rd_data, busy, done
  );

  modport slave (
    input  data_input, ready, level, edge_sel, decim, pretrig,
           arm, force_trig, rd_addr,
    output rd_data, busy, done
  );
endinterface

// File: rtl/trigger_capture.sv
// ---------------------------------------------------------------------------
// trigger_capture
//   Hysteretic edge trigger with selectable slope, sample decimation,
//   programmable pre-trigger depth and a circular capture memory. Once a
//   capture completes, a DEPTH-sample frame is readable through a registered
//   read port addressed relative to the oldest sample of the frame.
//
//   clk   clock
//   rst   asynchronous active-high reset
//   bus   trigger_capture_if.slave (sample stream, controls, read port)
//
//   Parameters: DATA_W sample width, DEPTH frame length (power of two, >= 4),
//   ADDR_W address width, DECIM_W decimation width, HYST hysteresis
//   half-band in LSBs.
// ---------------------------------------------------------------------------
module trigger_capture #(
  parameter int DATA_W  = 12,
  parameter int DEPTH   = 512,
  parameter int ADDR_W  = $clog2(DEPTH),
  parameter int DECIM_W = 12,
  parameter int HYST    = 8
) (
  input  logic             clk,
  input  logic             rst,
  trigger_capture_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PRE,
    S_ARMED,
    S_POST,
    S_DONE
  } state_t;

  localparam logic signed [DATA_W+1:0] HYST_S = (DATA_W+2)'(HYST);
  localparam logic signed [DATA_W+1:0] MAX_S  = (DATA_W+2)'((1 << DATA_W) - 1);
  localparam logic [ADDR_W-1:0]        A_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W-1:0]        A_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [DECIM_W-1:0]       D_ONE  = DECIM_W'(1);

  // Lower threshold: level - HYST, clamped at zero. Computed one bit wider
  // than a sample plus a sign bit so the subtraction cannot wrap.
  function automatic logic [DATA_W:0] sat_lo(input logic [DATA_W-1:0] lvl);
    logic signed [DATA_W+1:0] d;
    d = $signed({2'b00, lvl}) - HYST_S;
    if (d[DATA_W+1]) sat_lo = '0;
    else             sat_lo = d[DATA_W:0];
  endfunction

  // Upper threshold: level + HYST, clamped at full scale.
  function automatic logic [DATA_W:0] sat_hi(input logic [DATA_W-1:0] lvl);
    logic signed [DATA_W+1:0] s;
    s = $signed({2'b00, lvl}) + HYST_S;
    if (s > MAX_S) sat_hi = MAX_S[DATA_W:0];
    else           sat_hi = s[DATA_W:0];
  endfunction

  state_t              state, state_n;
  logic [DECIM_W-1:0]  dcnt, dcnt_n;
  logic [ADDR_W-1:0]   wptr, wptr_n;
  logic [ADDR_W-1:0]   pcnt, pcnt_n;
  logic [ADDR_W-1:0]   start, start_n;
  logic [ADDR_W-1:0]   pre_lat, pre_lat_n;
  logic                edge_lat, edge_lat_n;
  logic                primed, primed_n;

  logic [DATA_W:0]     lo_th;
  logic [DATA_W:0]     hi_th;
  logic [DATA_W:0]     samp_x;
  logic                vld_p0;
  logic                we_p0;
  logic                prime_hit;
  logic                trig_hit;
  logic [ADDR_W-1:0]   rd_idx;

  logic [DATA_W-1:0]   mem [DEPTH];
  logic [DATA_W-1:0]   rd_data_p1;

  // ---- stage p0: sample qualification and threshold compare ----
  assign lo_th  = sat_lo(bus.level);
  assign hi_th  = sat_hi(bus.level);
  assign samp_x = {1'b0, bus.data_input};

  // An arm in the same cycle discards the sample it coincides with.
  assign vld_p0 = bus.ready && (dcnt == bus.decim) && !bus.arm;

  // Priming needs the signal to leave the band on the far side first;
  // that is what gives the trigger its hysteresis.
  assign prime_hit = edge_lat ? (samp_x > hi_th)  : (samp_x < lo_th);
  assign trig_hit  = edge_lat ? (samp_x <= lo_th) : (samp_x >= hi_th);

  always_comb begin
    state_n    = state;
    dcnt_n     = dcnt;
    wptr_n     = wptr;
    pcnt_n     = pcnt;
    start_n    = start;
    pre_lat_n  = pre_lat;
    edge_lat_n = edge_lat;
    primed_n   = primed;
    we_p0      = 1'b0;

    if (bus.ready) begin
      dcnt_n = (dcnt == bus.decim) ? '0 : dcnt + D_ONE;
    end

    if (bus.arm) begin
      dcnt_n     = '0;
      wptr_n     = '0;
      pcnt_n     = '0;
      primed_n   = 1'b0;
      pre_lat_n  = bus.pretrig;
      edge_lat_n = bus.edge_sel;
      state_n    = (bus.pretrig == '0) ? S_ARMED : S_PRE;
    end else if (vld_p0) begin
      unique case (state)
        S_PRE: begin
          we_p0  = 1'b1;
          wptr_n = wptr + A_ONE;
          pcnt_n = pcnt + A_ONE;
          if (prime_hit) primed_n = 1'b1;
          if (pcnt_n == pre_lat) state_n = S_ARMED;
        end
        S_ARMED: begin
          we_p0  = 1'b1;
          wptr_n = wptr + A_ONE;
          if (bus.force_trig || (primed && trig_hit)) begin
            // The trigger sample is the first post sample; the frame
            // starts pre_lat entries behind it, modulo the ring size.
            primed_n = 1'b0;
            start_n  = wptr - pre_lat;
            pcnt_n   = A_LAST - pre_lat;
            state_n  = (pcnt_n == '0) ? S_DONE : S_POST;
          end else if (prime_hit) begin
            primed_n = 1'b1;
          end
        end
        S_POST: begin
          we_p0  = 1'b1;
          wptr_n = wptr + A_ONE;
          pcnt_n = pcnt - A_ONE;
          if (pcnt == A_ONE) state_n = S_DONE;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      dcnt     <= '0;
      wptr     <= '0;
      pcnt     <= '0;
      start    <= '0;
      pre_lat  <= '0;
      edge_lat <= 1'b0;
      primed   <= 1'b0;
    end else begin
      state    <= state_n;
      dcnt     <= dcnt_n;
      wptr     <= wptr_n;
      pcnt     <= pcnt_n;
      start    <= start_n;
      pre_lat  <= pre_lat_n;
      edge_lat <= edge_lat_n;
      primed   <= primed_n;
    end
  end

  // ---- stage p1: capture memory write and registered read ----
  assign rd_idx = start + bus.rd_addr;

  always_ff @(posedge clk) begin
    if (we_p0) mem[wptr] <= bus.data_input;
  end

  // Read and write sit in separate nonblocking processes, so a read of the
  // address being written returns the previous contents.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_data_p1 <= '0;
    else     rd_data_p1 <= mem[rd_idx];
  end

  assign bus.rd_data = rd_data_p1;
  assign bus.busy    = (state == S_PRE) || (state == S_ARMED) || (state == S_POST);
  assign bus.done    = (state == S_DONE);

endmodule
